seg_scan_encoder: RTL
=====================

SEG_SCAN_ENCODER -- requirements
Module: seg_scan_encoder

Interface
REQ-001 NUM_SW, default 16, number of switch inputs; legal range 1..256.
REQ-002 REFRESH_CYCLES, default 100000, clk cycles each digit is lit.
REQ-003 DEBOUNCE_CYCLES, default 1000000, cycles btnR must be stable before acceptance.
REQ-004 clk  input  1  system clock (100 MHz); the block has one clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sw  input  NUM_SW  switch inputs, asynchronous to clk.
REQ-007 btnR  input  1  mode-toggle button, asynchronous, bouncy.
REQ-008 an  output  4  digit anodes, active-low.
REQ-009 seg  output  8  cathodes {dp,g..a}, active-low.
REQ-010 led  output  NUM_SW  one-hot marker of the selected switch.

Function
REQ-011 sw and btnR SHALL each pass through a two-flop synchroniser before any use.
REQ-012 Synchronised btnR SHALL be accepted only after DEBOUNCE_CYCLES consecutive equal samples; each accepted 0->1 transition toggles mode; a held button gives exactly one toggle.
REQ-013 Mode LOW SHALL select the lowest-index set switch; mode HIGH SHALL select the highest-index set switch.
REQ-014 Encoder SHALL register each cycle: active (any switch set) and idx (selected index, width clog2(NUM_SW), minimum 1 bit).
REQ-015 led SHALL equal one-hot(idx) when active, else all zero; led is registered, 4 cycles after an sw edge (2 sync + encode + output).
REQ-016 A refresh counter SHALL count 0..REFRESH_CYCLES-1 and wrap; on wrap, digit pointer ptr advances 0->1->2->3->0.
REQ-017 On wrap with ptr==3 (frame boundary), a display snapshot {active, idx, mode} SHALL be captured; digits show only snapshot data, so no value changes mid-frame.
REQ-018 an SHALL be all ones except bit ptr, which is 0.
REQ-019 Digit 0 SHALL show hex idx[3:0]; digit 1 hex idx[7:4], blank when idx[7:4]==0; digit 2 always blank; digit 3 glyph L (mode LOW) or H (mode HIGH).
REQ-020 When snapshot active==0, digits 0 and 1 SHALL show dash; digit 3 still shows mode.
REQ-021 an and seg SHALL be registered and change together, one cycle after ptr changes; dp SHALL be 1 (off).
REQ-022 Mode toggle and frame boundary in the same cycle: the snapshot SHALL capture the pre-toggle mode; the new mode appears next frame.
REQ-023 Switch changes within a frame SHALL affect led immediately (per REQ-015) but display only at the next frame boundary.

Reset
REQ-024 While rst=1: an=4'b1111, seg=8'hFF, led=0, ptr=0, refresh counter=0, mode=LOW, snapshot active=0, idx=0, debouncer state=released, synchroniser flops=0.
REQ-025 rst asserted mid-frame or mid-debounce SHALL abort the operation; no toggle is generated by a debounce in progress.
REQ-026 First frame after rst release SHALL start at ptr=0 with a full REFRESH_CYCLES dwell and show dash/dash/blank/L until the first frame boundary.

Structure
REQ-027 Shared package seg_disp_pkg SHALL hold glyph constants (0-F, L, H, dash=8'hBF, blank=8'hFF), anode patterns and the mode enum {MODE_LOW, MODE_HIGH}.
REQ-028 Debounce SHALL be a sub-module btn_debounce (parameter DEBOUNCE_CYCLES, outputs level and one-cycle rise pulse); encoder, scan and glyph logic stay in seg_scan_encoder.

Verification (REFRESH_CYCLES=4, DEBOUNCE_CYCLES=3, NUM_SW=16 unless stated)
REQ-029 Reset release, sw=0 -> an sequence 1110,1101,1011,0111, 4 cycles each; seg dash, dash, FF, L glyph; led=0.
REQ-030 sw=16'h0024, mode LOW -> led=16'h0004 four cycles later; after next frame boundary digit 0 shows 2 (8'hA4), digit 1 blank.
REQ-031 btnR high 1 cycle, then bouncing 0/1 for 2 cycles, then stable high 10 cycles -> exactly one toggle to HIGH; with sw=16'h0024, led=16'h0020; next frame digit 0 shows 5, digit 3 shows H.
REQ-032 NUM_SW=32, sw bit 26 only -> digit 1 shows 1, digit 0 shows A.
REQ-033 sw changed mid-frame, then rst pulsed 1 cycle at ptr=2 -> all outputs reach reset values next cycle; scan restarts at ptr=0.
REQ-034 btnR debounce completing in the same cycle as the frame boundary -> current frame keeps old mode letter; the following frame shows the new one.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared display definitions: active-low 7-segment glyphs {dp,g..a}, anode patterns
// and the switch-selection mode.
package seg_disp_pkg;

  typedef enum logic {
    MODE_LOW  = 1'b0,
    MODE_HIGH = 1'b1
  } mode_e;

  localparam logic [7:0] GLYPH_DASH  = 8'hBF;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_L     = 8'hC7;
  localparam logic [7:0] GLYPH_H     = 8'h89;
  localparam logic [3:0] AN_OFF      = 4'b1111;

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [3:0] anode_sel(input logic [1:0] ptr);
    return ~(4'b0001 << ptr);
  endfunction

endpackage

// File: rtl/seg_scan_encoder_if.sv
// Board-facing signals of the switch encoder / display scanner.
interface seg_scan_encoder_if #(
  parameter int NUM_SW = 16
);
  logic [NUM_SW-1:0] sw;
  logic              btnR;
  logic [3:0]        an;
  logic [7:0]        seg;
  logic [NUM_SW-1:0] led;

  modport master (output sw, output btnR, input an, input seg, input led);
  modport slave  (input sw, input btnR, output an, output seg, output led);
endinterface

// File: rtl/btn_debounce.sv
// Accepts a new button level only after DEBOUNCE_CYCLES consecutive samples that
// differ from the current level; rise pulses for one cycle on an accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  output logic level,
  output logic rise
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sample != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sample;
          rise  <= sample;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/seg_scan_encoder.sv
// Priority-encodes the switches (lowest or highest set, toggled by btnR), marks the
// choice on led and scans the index and mode onto a 4-digit multiplexed display.
module seg_scan_encoder
  import seg_disp_pkg::*;
#(
  parameter int NUM_SW          = 16,
  parameter int REFRESH_CYCLES  = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic               clk,
  input logic               rst,
  seg_scan_encoder_if.slave bus
);
  localparam int IDX_W = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
  localparam int RC_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [NUM_SW-1:0] sw_p0, sw_p1;
  logic              btn_p0, btn_p1;
  logic              btn_level, btn_rise;
  mode_e             mode;
  logic              enc_found;
  logic [IDX_W-1:0]  enc_idx;
  logic              vld_p2;
  logic [IDX_W-1:0]  idx_p2;
  logic [NUM_SW-1:0] led_p3;
  logic [RC_W-1:0]   rcnt;
  logic [1:0]        ptr;
  logic              snap_vld;
  logic [IDX_W-1:0]  snap_idx;
  mode_e             snap_mode;
  logic [7:0]        snap_idx8;
  logic [7:0]        glyph;
  logic [3:0]        an_r;
  logic [7:0]        seg_r;

  // p0/p1: two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_p0  <= '0;
      sw_p1  <= '0;
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      sw_p0  <= bus.sw;
      sw_p1  <= sw_p0;
      btn_p0 <= bus.btnR;
      btn_p1 <= btn_p0;
    end
  end

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .sample (btn_p1),
    .level  (btn_level),
    .rise   (btn_rise)
  );

  // In LOW mode the first hit wins; in HIGH mode every later hit overrides.
  always_comb begin
    enc_found = 1'b0;
    enc_idx   = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (sw_p1[i]) begin
        if (mode == MODE_HIGH || !enc_found) enc_idx = IDX_W'(i);
        enc_found = 1'b1;
      end
    end
  end

  // p2: registered encoder result; p3: one-hot led
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      idx_p2 <= '0;
      led_p3 <= '0;
    end else begin
      vld_p2 <= enc_found;
      idx_p2 <= enc_idx;
      led_p3 <= vld_p2 ? (NUM_SW'(1) << idx_p2) : '0;
    end
  end

  assign snap_idx8 = 8'(snap_idx);

  always_comb begin
    case (ptr)
      2'd0:    glyph = snap_vld ? hex_glyph(snap_idx8[3:0]) : GLYPH_DASH;
      2'd1:    glyph = !snap_vld ? GLYPH_DASH :
                       (snap_idx8[7:4] == 4'h0) ? GLYPH_BLANK : hex_glyph(snap_idx8[7:4]);
      2'd2:    glyph = GLYPH_BLANK;
      default: glyph = (snap_mode == MODE_HIGH) ? GLYPH_H : GLYPH_L;
    endcase
  end

  // Snapshot is taken with the pre-edge mode, so a toggle landing on the frame
  // boundary only shows up one frame later.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode      <= MODE_LOW;
      rcnt      <= '0;
      ptr       <= 2'd0;
      snap_vld  <= 1'b0;
      snap_idx  <= '0;
      snap_mode <= MODE_LOW;
      an_r      <= AN_OFF;
      seg_r     <= GLYPH_BLANK;
    end else begin
      if (btn_rise && btn_level) mode <= (mode == MODE_LOW) ? MODE_HIGH : MODE_LOW;
      if (rcnt == RC_W'(REFRESH_CYCLES - 1)) begin
        rcnt <= '0;
        ptr  <= ptr + 2'd1;
        if (ptr == 2'd3) begin
          snap_vld  <= vld_p2;
          snap_idx  <= idx_p2;
          snap_mode <= mode;
        end
      end else begin
        rcnt <= rcnt + RC_W'(1);
      end
      an_r  <= anode_sel(ptr);
      seg_r <= glyph;
    end
  end

  assign bus.an  = an_r;
  assign bus.seg = seg_r;
  assign bus.led = led_p3;
endmodule
